// File: rtl/mem_port_rr_arbiter_pkg.sv
// rtl/mem_port_rr_arbiter_pkg.sv - shared types, sizes and index helpers for the round-robin port arbiter
package mem_port_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } arbState_t;

  // Index arithmetic wraps naturally at SEL_W bits, giving mod-NUM_REQ rotation.
  function automatic logic [SEL_W-1:0] nextIdx(input logic [SEL_W-1:0] idx);
    return SEL_W'(idx + 1'b1);
  endfunction

  function automatic logic [NUM_REQ-1:0] idxToOneHot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mem_port_rr_arbiter_if.sv
// rtl/mem_port_rr_arbiter_if.sv - request/grant and shared-port handshake bundle for the arbiter
interface mem_port_rr_arbiter_if
  import mem_port_rr_arbiter_pkg::*;
  ();

  logic [NUM_REQ-1:0] Req;
  logic               MemReady;
  logic [NUM_REQ-1:0] Grant;
  logic [SEL_W-1:0]   Sel;
  logic               MemStart;
  logic [NUM_REQ-1:0] Ack;
  logic               Busy;
  logic               Timeout;

  modport master (
    input  Req, MemReady,
    output Grant, Sel, MemStart, Ack, Busy, Timeout
  );

  modport slave (
    output Req, MemReady,
    input  Grant, Sel, MemStart, Ack, Busy, Timeout
  );

endinterface

// File: rtl/mem_port_rr_arbiter_rr_priority_pick.sv
// rtl/mem_port_rr_arbiter_rr_priority_pick.sv - combinational rotate/find-first starting at ptr
module rr_priority_pick
  import mem_port_rr_arbiter_pkg::*;
  (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               valid,
    output logic [SEL_W-1:0]   idx
  );

  logic [SEL_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = SEL_W'(ptr + SEL_W'(k));
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_rr_arbiter.sv
// rtl/mem_port_rr_arbiter.sv - 4-way round-robin arbiter for one shared memory port
// Optional forced release after MAX_WAIT busy cycles when ARB_TIMEOUT_EN is defined.
module mem_port_rr_arbiter
  import mem_port_rr_arbiter_pkg::*;
  #(
    parameter int MAX_WAIT = 16
  )
  (
    input logic                   Clk,
    input logic                   Reset,
    mem_port_rr_arbiter_if.master bus
  );

  if (MAX_WAIT < 2) begin : gBadMaxWait
    $error("MAX_WAIT must be at least 2");
  end

  arbState_t          state, stateNext;
  logic [NUM_REQ-1:0] grantQ, grantNext;
  logic [NUM_REQ-1:0] ackQ, ackNext;
  logic [SEL_W-1:0]   selQ, selNext;
  logic [SEL_W-1:0]   ptrQ, ptrNext;
  logic               pickValid;
  logic [SEL_W-1:0]   pickIdx;
  logic               doRelease;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] waitCnt, waitCntNext;
  logic             timeoutQ, timeoutNext;
`endif

  rr_priority_pick uPick (
    .req   (bus.Req),
    .ptr   (ptrQ),
    .valid (pickValid),
    .idx   (pickIdx)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      grantQ   <= '0;
      ackQ     <= '0;
      selQ     <= '0;
      ptrQ     <= '0;
`ifdef ARB_TIMEOUT_EN
      waitCnt  <= '0;
      timeoutQ <= 1'b0;
`endif
    end else begin
      grantQ   <= grantNext;
      ackQ     <= ackNext;
      selQ     <= selNext;
      ptrQ     <= ptrNext;
`ifdef ARB_TIMEOUT_EN
      waitCnt  <= waitCntNext;
      timeoutQ <= timeoutNext;
`endif
    end
  end

  always_comb begin
    stateNext   = state;
    grantNext   = grantQ;
    selNext     = selQ;
    ptrNext     = ptrQ;
    ackNext     = '0;
    doRelease   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    waitCntNext = waitCnt;
    timeoutNext = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (pickValid) begin
          stateNext = ISSUE;
          grantNext = idxToOneHot(pickIdx);
          selNext   = pickIdx;
        end
      end
      ISSUE: begin
`ifdef ARB_TIMEOUT_EN
        waitCntNext = '0;
`endif
        if (bus.MemReady) begin
          doRelease = 1'b1;
        end else begin
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (bus.MemReady) begin
          doRelease = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (waitCnt == CNT_W'(MAX_WAIT - 1)) begin
          // This busy cycle is the MAX_WAIT-th; ready on the same cycle wins above.
          doRelease   = 1'b1;
          timeoutNext = 1'b1;
        end else begin
          waitCntNext = CNT_W'(waitCnt + 1'b1);
`endif
        end
      end
      RELEASE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // Sel keeps the finished index through RELEASE; only Grant drops.
    if (doRelease) begin
      stateNext = RELEASE;
      ackNext   = grantQ;
      grantNext = '0;
      ptrNext   = nextIdx(selQ);
    end
  end

  assign bus.Grant    = grantQ;
  assign bus.Sel      = selQ;
  assign bus.Ack      = ackQ;
  assign bus.MemStart = (state == ISSUE);
  assign bus.Busy     = (state != IDLE);
`ifdef ARB_TIMEOUT_EN
  assign bus.Timeout  = timeoutQ;
`else
  assign bus.Timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_rr_arbiter.sv
// tb/tb_mem_port_rr_arbiter.sv - directed self-checking bench with grant-order scoreboard
module tb_mem_port_rr_arbiter;

  logic Clk;
  logic Reset;
  int   nCompared;
  int   nMismatch;
  int   tbPtr;
  int   sbQ[$];

  mem_port_rr_arbiter_if bus ();

  mem_port_rr_arbiter #(.MAX_WAIT(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int modelPick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] oneHot(input int i);
    logic [3:0] v;
    v = 4'b0000;
    if (i >= 0 && i < 4) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int decode(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v == oneHot(i)) return i;
    end
    return -1;
  endfunction

  task automatic checkAllZero(input string tag);
    check({tag, ".grant"},    bus.Grant,    0);
    check({tag, ".sel"},      bus.Sel,      0);
    check({tag, ".memStart"}, bus.MemStart, 0);
    check({tag, ".ack"},      bus.Ack,      0);
    check({tag, ".busy"},     bus.Busy,     0);
    check({tag, ".timeout"},  bus.Timeout,  0);
  endtask

  task automatic resetDut();
    Reset        = 1'b1;
    bus.Req      = 4'b0000;
    bus.MemReady = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    tbPtr = 0;
    sbQ.delete();
  endtask

  // One full access: Req raised in IDLE, MemReady after `delay` busy cycles.
  task automatic access(input logic [3:0] r, input int delay, input string tag, output int gotIdx);
    int g;
    int e;
    int waited;
    g = modelPick(r, tbPtr);
    sbQ.push_back(g);
    bus.Req      = r;
    bus.MemReady = 1'b0;
    @(posedge Clk); #1;
    check({tag, ".issueGrant"}, bus.Grant,    oneHot(g));
    check({tag, ".issueSel"},   bus.Sel,      g);
    check({tag, ".memStart"},   bus.MemStart, 1);
    check({tag, ".issueBusy"},  bus.Busy,     1);
    for (int i = 0; i < delay; i++) begin
      @(posedge Clk); #1;
      check({tag, ".holdGrant"}, bus.Grant,    oneHot(g));
      check({tag, ".startLow"},  bus.MemStart, 0);
      check({tag, ".noTimeout"}, bus.Timeout,  0);
    end
    bus.MemReady = 1'b1;
    waited = 0;
    do begin
      @(posedge Clk); #1;
      waited++;
    end while (bus.Ack == 4'b0000 && waited < 8);
    check({tag, ".ackLatency"}, waited, 1);
    e = (sbQ.size() > 0) ? sbQ.pop_front() : -1;
    gotIdx = decode(bus.Ack);
    check({tag, ".ack"},        bus.Ack,     oneHot(e));
    check({tag, ".relGrant"},   bus.Grant,   0);
    check({tag, ".relSel"},     bus.Sel,     e);
    check({tag, ".relBusy"},    bus.Busy,    1);
    check({tag, ".relTimeout"}, bus.Timeout, 0);
    bus.Req      = 4'b0000;
    bus.MemReady = 1'b0;
    if (e >= 0) tbPtr = (e + 1) % 4;
    @(posedge Clk); #1;
    check({tag, ".idleAck"},  bus.Ack,  0);
    check({tag, ".idleBusy"}, bus.Busy, 0);
  endtask

  initial begin
    int got;
    int prev;
    int order[5];
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    nCompared = 0;
    nMismatch = 0;

    resetDut();
    checkAllZero("postReset");

    // Async reset mid-cycle while in ISSUE.
    bus.Req = 4'b0100;
    @(posedge Clk); #1;
    check("t1.issueGrant", bus.Grant, 4'b0100);
    #3 Reset = 1'b1;
    #1 checkAllZero("t1.asyncReset");
    bus.Req = 4'b0000;
    @(posedge Clk); #1;
    Reset = 1'b0;
    tbPtr = 0;
    sbQ.delete();

    // Rotation from ptr 0 with sparse requests.
    access(4'b1010, 0, "t4a", got);
    check("t4a.idx", got, 1);
    access(4'b1010, 1, "t4b", got);
    check("t4b.idx", got, 3);
    access(4'b0010, 0, "t4c", got);
    check("t4c.idx", got, 1);
    access(4'b0001, 0, "t4d", got);
    check("t4d.idx", got, 0);

    // Single requester with delayed ready, then confirm ptr moved to 3.
    access(4'b0100, 2, "t2", got);
    check("t2.idx", got, 2);
    access(4'b1001, 0, "t2ptr", got);
    check("t2ptr.idx", got, 3);

    // All requesting: strict rotation, never the same winner twice in a row.
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      access(4'b1111, (i % 2) * 2, "t3", got);
      check("t3.order", got, order[i]);
      check("t3.noRepeat", (got != prev), 1);
      prev = got;
    end

    // Reset while BUSY with Grant 0010; ptr must come back to 0.
    bus.Req = 4'b0010;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("t5.busyGrant", bus.Grant, 4'b0010);
    check("t5.busyState", bus.Busy,  1);
    #3 Reset = 1'b1;
    #1;
    check("t5.resetGrant", bus.Grant, 0);
    check("t5.resetBusy",  bus.Busy,  0);
    bus.Req = 4'b0000;
    @(posedge Clk); #1;
    Reset = 1'b0;
    tbPtr = 0;
    sbQ.delete();
    access(4'b1111, 0, "t5post", got);
    check("t5post.idx", got, 0);

`ifdef ARB_TIMEOUT_EN
    begin
      int g;
      int e;
      g = modelPick(4'b1000, tbPtr);
      sbQ.push_back(g);
      bus.Req      = 4'b1000;
      bus.MemReady = 1'b0;
      @(posedge Clk); #1;
      check("t6.issueGrant", bus.Grant, oneHot(g));
      for (int i = 0; i < 8; i++) begin
        @(posedge Clk); #1;
        check("t6.busyAck",     bus.Ack,     0);
        check("t6.busyTimeout", bus.Timeout, 0);
      end
      @(posedge Clk); #1;
      e = (sbQ.size() > 0) ? sbQ.pop_front() : -1;
      check("t6.timeoutAck", bus.Ack,     oneHot(e));
      check("t6.timeout",    bus.Timeout, 1);
      check("t6.relGrant",   bus.Grant,   0);
      bus.Req = 4'b0000;
      tbPtr = (e + 1) % 4;
      @(posedge Clk); #1;
      check("t6.timeoutPulse", bus.Timeout, 0);
      access(4'b1111, 0, "t6ptr", got);
      check("t6ptr.idx", got, 0);
    end
`else
    access(4'b1000, 100, "t6", got);
    check("t6.idx", got, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
